// File: rtl/fpu_issue_ctrl.sv
// Command stage for the fpu core: buffers requests in a FIFO, sequences each one
// through a reset/settle/run cycle and returns the result, with a watchdog abort.
module fpu_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_opcode,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        fpu_rst,
    output logic        fpu_start,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_opcode,
    input  logic [31:0] fpu_z,
    input  logic [2:0]  fpu_error,
    input  logic        fpu_done,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_z,
    output logic [2:0]  res_error,
    output logic        res_timeout,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_RUN,
        S_RESULT
    } state_e;

    state_e state_q, state_d;

    logic [65:0]      mem_q [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [TO_W-1:0]  to_cnt_q;

    logic [31:0] fpu_a_q, fpu_b_q;
    logic [1:0]  fpu_op_q;
    logic [31:0] res_z_q;
    logic [2:0]  res_error_q;
    logic        res_timeout_q;

    logic push, pop, to_hit;

    assign cmd_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state_q == S_IDLE) & (count_q != '0);
    assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT - 1));

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_opcode, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pop) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_RUN;
            S_RUN:    if (fpu_done || to_hit) state_d = S_RESULT;
            S_RESULT: if (res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fpu_rst   = rst | (state_q == S_CLEAR);
        fpu_start = (state_q == S_RUN);
        res_valid = (state_q == S_RESULT);
        busy      = (count_q != '0) | (state_q != S_IDLE);
    end

    // Operand latch and result capture; fpu_done outranks the watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_op_q      <= '0;
            res_z_q       <= '0;
            res_error_q   <= '0;
            res_timeout_q <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            if (pop) begin
                {fpu_op_q, fpu_a_q, fpu_b_q} <= mem_q[rd_ptr_q];
            end
            case (state_q)
                S_SETTLE: to_cnt_q <= '0;
                S_RUN: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (fpu_done) begin
                        res_z_q       <= fpu_z;
                        res_error_q   <= fpu_error;
                        res_timeout_q <= 1'b0;
                    end else if (to_hit) begin
                        res_z_q       <= '0;
                        res_error_q   <= '1;
                        res_timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_opcode  = fpu_op_q;
    assign res_z       = res_z_q;
    assign res_error   = res_error_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a stand-in fpu and a result scoreboard.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [31:0] cmd_a, cmd_b;
    logic        fpu_rst, fpu_start;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_opcode;
    logic [31:0] fpu_z;
    logic [2:0]  fpu_error;
    logic        fpu_done;
    logic        res_valid, res_ready;
    logic [31:0] res_z;
    logic [2:0]  res_error;
    logic        res_timeout;
    logic        busy;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fpu_rst(fpu_rst), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_opcode(fpu_opcode), .fpu_z(fpu_z), .fpu_error(fpu_error), .fpu_done(fpu_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
        .res_error(res_error), .res_timeout(res_timeout), .busy(busy)
    );

    localparam logic [31:0] HANG_A = 32'hDEAD0001;  // fpu never finishes
    localparam logic [31:0] LATE_A = 32'hDEAD0064;  // fpu finishes on last watchdog cycle

    function automatic logic [31:0] model_z(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'b11 && b == 32'h0) return 32'h7F800000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    function automatic logic [2:0] model_err(input logic [1:0] op, input logic [31:0] b);
        return (op == 2'b11 && b == 32'h0) ? 3'b010 : 3'b000;
    endfunction

    function automatic int model_lat(input logic [31:0] a);
        return (a == LATE_A) ? 64 : 3;
    endfunction

    int run_cnt = 0;
    always @(posedge clk) begin
        if (fpu_rst || !fpu_start) run_cnt <= 0;
        else                       run_cnt <= run_cnt + 1;
    end
    assign fpu_done  = fpu_start && (fpu_a != HANG_A) && (run_cnt >= model_lat(fpu_a) - 1);
    assign fpu_z     = model_z(fpu_opcode, fpu_a, fpu_b);
    assign fpu_error = model_err(fpu_opcode, fpu_b);

    typedef struct packed {
        logic [31:0] z;
        logic [2:0]  err;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output logic acc);
        exp_t e;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        acc        = cmd_ready;
        if (acc) begin
            if (a == HANG_A) begin
                e.z = 32'h0; e.err = 3'b111; e.to = 1'b1;
            end else begin
                e.z = model_z(op, a, b); e.err = model_err(op, b); e.to = 1'b0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, output exp_t e);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb observed=result expected=none", tag);
            e = '0;
        end else begin
            e = sb.pop_front();
            check({tag, "_z"},  64'(res_z),       64'(e.z));
            check({tag, "_err"}, 64'(res_error),  64'(e.err));
            check({tag, "_to"},  64'(res_timeout), 64'(e.to));
        end
    endtask

    task automatic collect(input string tag, input int exp_lat, output exp_t e);
        bit seen;
        int n;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = fpu_start;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_start observed=0 expected=1", tag);
        end
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            n++;
            seen = res_valid;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        pop_check(tag, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        exp_t e, held;

        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_fpu_rst",   64'(fpu_rst),   64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_res_z",     64'(res_z),     64'd0);
        check("rst_start",     64'(fpu_start), 64'd0);
        check("rst_fpu_a",     64'(fpu_a),     64'd0);
        rst = 1'b0;

        // 1: single op with detailed sequencing
        res_ready = 1'b1;
        push(2'b00, 32'h3F800000, 32'h40000000, acc);
        check("t1_acc", 64'(acc), 64'd1);
        @(negedge clk);
        check("t1_idle_rst",  64'(fpu_rst), 64'd0);
        check("t1_idle_busy", 64'(busy),    64'd1);
        @(negedge clk);
        check("t1_clear_rst",   64'(fpu_rst),    64'd1);
        check("t1_clear_start", 64'(fpu_start),  64'd0);
        check("t1_clear_a",     64'(fpu_a),      64'h3F800000);
        check("t1_clear_b",     64'(fpu_b),      64'h40000000);
        check("t1_clear_op",    64'(fpu_opcode), 64'd0);
        @(negedge clk);
        check("t1_settle_rst",   64'(fpu_rst),   64'd0);
        check("t1_settle_start", 64'(fpu_start), 64'd0);
        collect("t1", 3, e);
        @(negedge clk);
        check("t1_post_valid", 64'(res_valid), 64'd0);
        check("t1_post_busy",  64'(busy),      64'd0);

        // 2: fill FIFO while a result is stalled, then drain in order
        res_ready = 1'b0;
        push(2'b01, 32'h11110000, 32'h00002222, acc);
        collect("t2_first", 3, held);
        for (int i = 0; i < 5; i++) begin
            push(2'(i), 32'h20000000 + 32'(i), 32'h00300000 + 32'(i), acc);
            check($sformatf("t2_acc%0d", i), 64'(acc), (i < 4) ? 64'd1 : 64'd0);
        end
        check("t2_full_ready", 64'(cmd_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t2_stall_valid%0d", i), 64'(res_valid), 64'd1);
            check($sformatf("t2_stall_z%0d", i),     64'(res_z),     64'(held.z));
        end
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            collect($sformatf("t2_q%0d", i), 3, e);
        end
        check("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: watchdog abort, then the next queued command runs normally
        push(2'b00, HANG_A, 32'h00000001, acc);
        push(2'b01, 32'h12345678, 32'h9ABCDEF0, acc);
        collect("t3_to", 64, e);
        collect("t3_next", 3, e);

        // 4: done coincides with the last watchdog cycle
        push(2'b10, LATE_A, 32'h00000005, acc);
        collect("t4", 64, e);

        // 6: error code passthrough
        push(2'b11, 32'h3F800000, 32'h00000000, acc);
        collect("t6", 3, e);

        // 5: reset mid-RUN with three queued commands
        push(2'b00, HANG_A, 32'h0, acc);
        push(2'b01, 32'h00000010, 32'h00000020, acc);
        push(2'b10, 32'h00000030, 32'h00000040, acc);
        push(2'b11, 32'h00000050, 32'h00000060, acc);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = fpu_start;
            end
            check("t5_running", 64'(seen), 64'd1);
        end
        rst = 1'b1;
        #1 check("t5_fpu_rst", 64'(fpu_rst), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        check("t5_valid", 64'(res_valid), 64'd0);
        check("t5_busy",  64'(busy),      64'd0);
        check("t5_ready", 64'(cmd_ready), 64'd1);
        check("t5_start", 64'(fpu_start), 64'd0);
        check("t5_rst_lo", 64'(fpu_rst),  64'd0);
        repeat (4) @(negedge clk);
        check("t5_hold_busy",  64'(busy),      64'd0);
        check("t5_hold_start", 64'(fpu_start), 64'd0);
        push(2'b01, 32'hCAFEF00D, 32'h0BADBEEF, acc);
        collect("t5_after", 3, e);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
